// File: rtl/current_adc_sampler.sv
// current_adc_sampler: periodic 12-bit serial ADC reader with power-of-two sample averaging.
// Ports:
//   clk            system clock, all logic on rising edge
//   rst_n          synchronous active-low reset
//   adc_miso       serial data from the ADC
//   adc_cs_n       ADC chip select, active-low
//   adc_sclk       ADC serial clock, idle low
//   adc_raw        last raw conversion result
//   current_b_out  average of the last 2^AVG_LOG2 conversions
//   sample_valid   one-cycle pulse when current_b_out updates
module current_adc_sampler #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 5000,
  parameter int AVG_LOG2      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adc_miso,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] adc_raw,
  output logic [11:0] current_b_out,
  output logic        sample_valid
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int AW = 12 + AVG_LOG2;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE} state_t;
  state_t                r_state, w_next;
  logic [DW-1:0]         r_div;
  logic [PW-1:0]         r_per;
  logic                  r_tick;
  logic                  r_sclk;
  logic [3:0]            r_bit;
  logic [11:0]           r_shift;
  logic [AW-1:0]         r_acc;
  logic [AVG_LOG2-1:0]   r_cnt;
  logic                  w_div_end, w_per_end, w_last;
  logic [AW-1:0]         w_sum;
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  assign w_per_end = r_per == PW'(SAMPLE_PERIOD - 1);
  assign w_last    = r_cnt == '1;
  assign w_sum     = r_acc + AW'(adc_raw);
  assign adc_sclk  = r_sclk;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next   = r_state;
    adc_cs_n = 1'b1;
    case (r_state)
      IDLE:     w_next = r_tick ? CS_SETUP : IDLE;
      CS_SETUP: begin adc_cs_n = 1'b0; w_next = w_div_end ? SHIFT : CS_SETUP; end
      SHIFT:    begin adc_cs_n = 1'b0; w_next = (w_div_end && r_sclk && r_bit == 4'd15) ? CS_HOLD : SHIFT; end
      CS_HOLD:  begin adc_cs_n = 1'b0; w_next = w_div_end ? UPDATE : CS_HOLD; end
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_per         <= '0;
      r_tick        <= 1'b0;
      r_div         <= '0;
      r_sclk        <= 1'b0;
      r_bit         <= '0;
      r_shift       <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      adc_raw       <= '0;
      current_b_out <= '0;
      sample_valid  <= 1'b0;
    end else begin
      r_per        <= w_per_end ? '0 : r_per + 1'b1;
      r_tick       <= w_per_end;
      sample_valid <= 1'b0;
      r_div        <= (!adc_cs_n && !w_div_end) ? r_div + 1'b1 : '0;
      if (r_state == SHIFT && w_div_end) begin
        r_sclk <= !r_sclk;
        // the 16th bit is a trailing null, so only bits 1-15 enter the shifter
        if (!r_sclk && r_bit != 4'd15) r_shift <= {r_shift[10:0], adc_miso};
        if (r_sclk) r_bit <= r_bit + 1'b1;
      end
      if (r_state == CS_HOLD && w_div_end) adc_raw <= r_shift;
      if (r_state == UPDATE) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_last ? '0 : w_sum;
        if (w_last) begin
          current_b_out <= w_sum[AW-1:AVG_LOG2];
          sample_valid  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_current_adc_sampler.sv
// tb_current_adc_sampler: directed checks of framing, averaging, reset abort and tick dropping.
module tb_current_adc_sampler;
  logic clk = 1'b0;
  logic rst0_n = 1'b0, rst1_n = 1'b0;
  logic miso0, cs0, sclk0, valid0;
  logic miso1, cs1, sclk1, valid1;
  logic [11:0] raw0, cbo0, raw1, cbo1;
  int checks = 0, errors = 0;
  int idx0 = 0, idx1 = 0, fc1 = 0, mode = 0;
  logic [15:0] word0 = {3'b000, 12'hA5A, 1'b0};
  logic [15:0] word1 = '0;
  int c, low, rises, frames, valids, rmin, rmax, gap;
  logic prev_s;

  always #5 clk = ~clk;

  current_adc_sampler #(.CLK_DIV(25), .SAMPLE_PERIOD(5000), .AVG_LOG2(3)) u0 (
    .clk(clk), .rst_n(rst0_n), .adc_miso(miso0), .adc_cs_n(cs0), .adc_sclk(sclk0),
    .adc_raw(raw0), .current_b_out(cbo0), .sample_valid(valid0));
  current_adc_sampler #(.CLK_DIV(25), .SAMPLE_PERIOD(800), .AVG_LOG2(3)) u1 (
    .clk(clk), .rst_n(rst1_n), .adc_miso(miso1), .adc_cs_n(cs1), .adc_sclk(sclk1),
    .adc_raw(raw1), .current_b_out(cbo1), .sample_valid(valid1));

  // ADC models: first bit valid at cs_n fall, next bit after each sclk fall
  always @(negedge cs0) idx0 = 0;
  always @(negedge sclk0) if (cs0 === 1'b0) idx0++;
  assign miso0 = (idx0 < 16) ? word0[15 - idx0] : 1'b0;
  always @(negedge cs1) begin
    word1 = {3'b000, (mode == 0) ? 12'd2600 : (mode == 1) ? (fc1[0] ? 12'd4095 : 12'd0) : 12'd4095, 1'b0};
    fc1++;
    idx1 = 0;
  end
  always @(negedge sclk1) if (cs1 === 1'b0) idx1++;
  assign miso1 = (idx1 < 16) ? word1[15 - idx1] : 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Watch u1 for n complete frames, then a few cycles so the last average can land
  task automatic run1(input int n, output int fr, output int vl, output int mn, output int mx, output int gp);
    int last_fall = -1, r = 0;
    logic pc = 1'b1, ps = 1'b0;
    fr = 0; vl = 0; mn = 99; mx = 0; gp = -1;
    for (int k = 0; k < n * 1600 + 1000 && fr < n; k++) begin
      tick();
      if (!cs1 && pc) begin
        if (last_fall >= 0) gp = k - last_fall;
        last_fall = k;
        r = 0;
      end
      if (sclk1 && !ps) r++;
      if (cs1 && !pc) begin
        fr++;
        mn = (r < mn) ? r : mn;
        mx = (r > mx) ? r : mx;
      end
      if (valid1) vl++;
      pc = cs1;
      ps = sclk1;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (valid1) vl++;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_cs_n", cs0, 1);
    chk("rst_sclk", sclk0, 0);
    chk("rst_raw", raw0, 0);
    chk("rst_cbo", cbo0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_cs_n_u1", cs1, 1);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    c = 0;
    while (cs0 && c < 6000) begin tick(); c++; end
    chk("first_cs_fall", c, 5001);
    low = 1; rises = 0; prev_s = sclk0;
    for (int k = 0; k < 1000 && !cs0; k++) begin
      tick();
      if (!cs0) low++;
      if (sclk0 && !prev_s) rises++;
      prev_s = sclk0;
    end
    chk("cs_low_width", low, 850);
    chk("sclk_rises", rises, 16);
    chk("raw_a5a", raw0, 12'hA5A);
    chk("sclk_idle", sclk0, 0);
    c = 0;
    while (cs0 && c < 6000) begin tick(); c++; end
    chk("second_cs_fall", c, 4150);
    repeat (400) tick();
    chk("in_shift_cs", cs0, 0);
    rst0_n = 1'b0;
    tick();
    chk("abort_cs_n", cs0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_cbo", cbo0, 0);
    chk("abort_raw", raw0, 0);
    rst0_n = 1'b1;
    c = 0;
    while (cs0 && c < 6000) begin tick(); c++; end
    chk("abort_next_fall", c, 5001);
    rst1_n = 1'b0;
    tick();
    rst1_n = 1'b1;
    run1(8, frames, valids, rmin, rmax, gap);
    chk("const_frames", frames, 8);
    chk("const_valids", valids, 1);
    chk("const_cbo", cbo1, 2600);
    chk("const_raw", raw1, 2600);
    chk("drop_min_rises", rmin, 16);
    chk("drop_max_rises", rmax, 16);
    chk("drop_gap", gap, 1600);
    mode = 1;
    fc1 = 0;
    run1(4, frames, valids, rmin, rmax, gap);
    chk("hold_valids", valids, 0);
    chk("hold_cbo", cbo1, 2600);
    run1(4, frames, valids, rmin, rmax, gap);
    chk("alt_valids", valids, 1);
    chk("alt_cbo", cbo1, 2047);
    chk("alt_raw", raw1, 4095);
    mode = 2;
    run1(8, frames, valids, rmin, rmax, gap);
    chk("max_valids", valids, 1);
    chk("max_cbo", cbo1, 4095);
    chk("max_rises", rmin, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/current_adc_sampler.md
CURRENT_ADC_SAMPLER -- requirements
Module: current_adc_sampler

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz clk).
REQ-002 The block SHALL have parameter SAMPLE_PERIOD, default 5000: clk cycles between conversion starts (100 us).
REQ-003 The block SHALL have parameter AVG_LOG2, default 3: log2 of the number of raw samples averaged per output.
REQ-004 The block SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port adc_miso  input  1  serial data from external 12-bit ADC.
REQ-007 The block SHALL have port adc_cs_n  output  1  ADC chip select, active-low.
REQ-008 The block SHALL have port adc_sclk  output  1  ADC serial clock, idle low.
REQ-009 The block SHALL have port adc_raw  output  12  last raw conversion result.
REQ-010 The block SHALL have port current_b_out  output  12  averaged current, unsigned, consumed by the overcurrent detector.
REQ-011 The block SHALL have port sample_valid  output  1  one-cycle pulse when current_b_out updates.

Function
REQ-012 A free-running period counter SHALL raise a start tick every SAMPLE_PERIOD cycles, counting from reset release.
REQ-013 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE; IDLE->CS_SETUP on start tick only.
REQ-014 CS_SETUP SHALL drive adc_cs_n=0, adc_sclk=0 for CLK_DIV cycles, then enter SHIFT.
REQ-015 SHIFT SHALL produce exactly 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high, then enter CS_HOLD with adc_sclk=0.
REQ-016 adc_miso SHALL be captured on the clk cycle where adc_sclk goes 0->1, shifted MSB-first into a 16-bit frame register.
REQ-017 Frame bit order: bits 1-3 ignored (null), bits 4-15 data MSB first, bit 16 ignored; adc_raw = frame[12:1].
REQ-018 CS_HOLD SHALL keep adc_cs_n=0 for CLK_DIV cycles, then deassert adc_cs_n and enter UPDATE; adc_raw updates on this exit.
REQ-019 adc_cs_n low width SHALL be exactly 34*CLK_DIV cycles per conversion.
REQ-020 UPDATE (one cycle) SHALL add adc_raw to a (12+AVG_LOG2)-bit accumulator and increment a sample count, then return to IDLE.
REQ-021 When the count reaches 2^AVG_LOG2, current_b_out SHALL load (accumulator incl. this sample) >> AVG_LOG2 (truncating), sample_valid SHALL pulse 1 cycle, and accumulator/count SHALL clear in the same cycle.
REQ-022 The accumulator SHALL never overflow (worst case 2^AVG_LOG2 * 4095 fits).
REQ-023 Start ticks arriving outside IDLE SHALL be ignored (no queuing); SAMPLE_PERIOD >= 34*CLK_DIV+2 is a usage constraint.
REQ-024 adc_sclk SHALL be 0 whenever adc_cs_n=1.
REQ-025 current_b_out SHALL hold its value between sample_valid pulses.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force: state IDLE, adc_cs_n=1, adc_sclk=0, adc_raw=0, current_b_out=0, sample_valid=0, accumulator, sample count, divider and period counter=0.
REQ-027 Reset mid-frame SHALL abort the frame with no partial result; the next start tick occurs SAMPLE_PERIOD cycles after reset release.

Verification
REQ-028 ADC model returns constant 2600 -> after 8 conversions current_b_out=2600, exactly one sample_valid pulse per 8 frames.
REQ-029 Model alternates 0/4095 over 8 frames -> current_b_out=2047 (16380>>3, truncated).
REQ-030 Frame pattern 000_1010_0101_1010_0 -> adc_raw=12'hA5A; cs_n low 850 cycles; 16 sclk rising edges.
REQ-031 All samples 4095 -> current_b_out=4095, no wrap.
REQ-032 rst_n low during SHIFT -> next cycle cs_n=1, sclk=0, current_b_out=0; next cs_n fall 5000+1 cycles after release.
REQ-033 SAMPLE_PERIOD=800 with CLK_DIV=25 (violating REQ-023) -> overlapping ticks dropped, every frame still 16 complete SCLK periods.
